// File: rtl/clock_mode_ctrl_pkg.sv
// Shared types and constants for the clock-calendar mode/setup controller.
package clock_mode_ctrl_pkg;

  typedef enum logic [0:0] {
    StRun   = 1'b0,
    StSetup = 1'b1
  } state_e;

  localparam int unsigned FldSec   = 0;
  localparam int unsigned FldMin   = 1;
  localparam int unsigned FldHour  = 2;
  localparam int unsigned FldDay   = 3;
  localparam int unsigned FldMonth = 4;
  localparam int unsigned FldYear  = 5;

  localparam logic BtnPressed = 1'b0;

  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic int unsigned num_pages(input int unsigned nf, input int unsigned fpp);
    return (nf + fpp - 1) / fpp;
  endfunction

endpackage

// File: rtl/clock_mode_ctrl_if.sv
// Button/tick inputs and display-control outputs of the mode controller.
interface clock_mode_ctrl_if #(
  parameter int unsigned NUM_FIELDS = 6,
  parameter int unsigned NUM_PAGES  = 2
);
  import clock_mode_ctrl_pkg::*;

  localparam int unsigned FieldW = idx_width(NUM_FIELDS);
  localparam int unsigned PageW  = idx_width(NUM_PAGES);

  logic                  tick;
  logic                  btn_mode_n;
  logic                  btn_next_n;
  logic                  display;
  logic [NUM_FIELDS-1:0] setup_n;
  logic [FieldW-1:0]     field_idx;
  logic [PageW-1:0]      page_sel;
  logic [NUM_FIELDS-1:0] blank_mask;

  modport master (
    output tick, btn_mode_n, btn_next_n,
    input  display, setup_n, field_idx, page_sel, blank_mask
  );

  modport slave (
    input  tick, btn_mode_n, btn_next_n,
    output display, setup_n, field_idx, page_sel, blank_mask
  );

endinterface

// File: rtl/clock_mode_ctrl_btn_debounce.sv
// Two-flop synchroniser, stable-sample debouncer and one-clock press pulse.
module clock_mode_ctrl_btn_debounce
  import clock_mode_ctrl_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYC = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_n,
  output logic press
);

  localparam int unsigned CntW = $clog2(DEBOUNCE_CYC + 1);

  logic            sync1_q, sync2_q;
  logic            level_q, level_d;
  logic            press_q, press_d;
  logic [CntW-1:0] cnt_q, cnt_d;

  // A differing sample only counts while consecutive; any agreeing sample restarts.
  always_comb begin
    level_d = level_q;
    cnt_d   = '0;
    press_d = 1'b0;
    if (sync2_q != level_q) begin
      if (cnt_q == CntW'(DEBOUNCE_CYC - 1)) begin
        level_d = sync2_q;
        press_d = (sync2_q == BtnPressed);
      end else begin
        cnt_d = cnt_q + CntW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1_q <= ~BtnPressed;
      sync2_q <= ~BtnPressed;
      level_q <= ~BtnPressed;
      cnt_q   <= '0;
      press_q <= 1'b0;
    end else begin
      sync1_q <= btn_n;
      sync2_q <= sync1_q;
      level_q <= level_d;
      cnt_q   <= cnt_d;
      press_q <= press_d;
    end
  end

  assign press = press_q;

endmodule

// File: rtl/clock_mode_ctrl.sv
// RUN/SETUP controller for the clock-calendar display with blink and auto-exit timeout.
// Optional AUTO_ROTATE_EN: cycle display pages every ROTATE_TICKS ticks while in RUN.
module clock_mode_ctrl
  import clock_mode_ctrl_pkg::*;
#(
  parameter int unsigned NUM_FIELDS      = 6,
  parameter int unsigned FIELDS_PER_PAGE = 3,
  parameter int unsigned BLINK_TICKS     = 1,
  parameter int unsigned TIMEOUT_TICKS   = 30,
  parameter int unsigned DEBOUNCE_CYC    = 4,
  parameter int unsigned ROTATE_TICKS    = 5
) (
  input logic             clk,
  input logic             rst,
  clock_mode_ctrl_if.slave bus
);

  localparam int unsigned NumPages = num_pages(NUM_FIELDS, FIELDS_PER_PAGE);
  localparam int unsigned FieldW   = idx_width(NUM_FIELDS);
  localparam int unsigned PageW    = idx_width(NumPages);
  localparam int unsigned BlinkW   = $clog2(BLINK_TICKS + 1);
  localparam int unsigned TmoW     = $clog2(TIMEOUT_TICKS + 1);

  logic mode_press, next_press;

  clock_mode_ctrl_btn_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_db_mode (
    .clk   (clk),
    .rst   (rst),
    .btn_n (bus.btn_mode_n),
    .press (mode_press)
  );

  clock_mode_ctrl_btn_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_db_next (
    .clk   (clk),
    .rst   (rst),
    .btn_n (bus.btn_next_n),
    .press (next_press)
  );

  state_e                state_q, state_d;
  logic [FieldW-1:0]     field_q, field_d, field_inc;
  logic [PageW-1:0]      page_q, page_d, page_inc;
  logic                  blink_q, blink_d;
  logic [BlinkW-1:0]     blink_cnt_q, blink_cnt_d, blink_cnt_inc;
  logic [TmoW-1:0]       tmo_q, tmo_d, tmo_inc;
  logic                  display_q;
  logic [NUM_FIELDS-1:0] setup_n_q, setup_n_d, blank_q, blank_d, sel;
`ifdef AUTO_ROTATE_EN
  localparam int unsigned RotW = $clog2(ROTATE_TICKS + 1);
  logic [RotW-1:0]       rot_q, rot_d, rot_inc;
  assign rot_inc = rot_q + RotW'(1);
`endif

  assign field_inc     = (field_q == FieldW'(NUM_FIELDS - 1)) ? '0 : field_q + FieldW'(1);
  assign page_inc      = (page_q == PageW'(NumPages - 1)) ? '0 : page_q + PageW'(1);
  assign blink_cnt_inc = blink_cnt_q + BlinkW'(1);
  assign tmo_inc       = tmo_q + TmoW'(1);

  always_comb begin
    state_d     = state_q;
    field_d     = field_q;
    page_d      = page_q;
    blink_d     = blink_q;
    blink_cnt_d = blink_cnt_q;
    tmo_d       = tmo_q;
`ifdef AUTO_ROTATE_EN
    rot_d       = rot_q;
`endif
    unique case (state_q)
      StRun: begin
        if (mode_press) begin
          state_d     = StSetup;
          field_d     = FieldW'(int'(page_q) * int'(FIELDS_PER_PAGE));
          blink_d     = 1'b0;
          blink_cnt_d = '0;
          tmo_d       = '0;
        end else if (next_press) begin
          page_d = page_inc;
`ifdef AUTO_ROTATE_EN
          rot_d  = '0;
        end else if (bus.tick) begin
          if (rot_inc == RotW'(ROTATE_TICKS)) begin
            page_d = page_inc;
            rot_d  = '0;
          end else begin
            rot_d = rot_inc;
          end
`endif
        end
      end
      StSetup: begin
        // Presses take priority over a coincident tick, so they also beat timeout expiry.
        if (mode_press || next_press) begin
          blink_d     = 1'b0;
          blink_cnt_d = '0;
          tmo_d       = '0;
          if (mode_press) begin
            state_d = StRun;
          end else begin
            field_d = field_inc;
            page_d  = PageW'(int'(field_inc) / int'(FIELDS_PER_PAGE));
          end
        end else if (bus.tick) begin
          if (blink_cnt_inc == BlinkW'(BLINK_TICKS)) begin
            blink_d     = ~blink_q;
            blink_cnt_d = '0;
          end else begin
            blink_cnt_d = blink_cnt_inc;
          end
          if (tmo_inc == TmoW'(TIMEOUT_TICKS)) begin
            state_d     = StRun;
            tmo_d       = '0;
            blink_d     = 1'b0;
            blink_cnt_d = '0;
          end else begin
            tmo_d = tmo_inc;
          end
        end
`ifdef AUTO_ROTATE_EN
        if (state_d == StRun) rot_d = '0;
`endif
      end
      default: state_d = StRun;
    endcase
  end

  // Output registers are loaded from next-state so they track the FSM with no extra lag.
  always_comb begin
    sel       = {{(NUM_FIELDS - 1){1'b0}}, 1'b1} << field_d;
    setup_n_d = (state_d == StSetup) ? ~sel : '1;
    blank_d   = (state_d == StSetup && blink_d) ? sel : '0;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= StRun;
      field_q     <= FieldW'(FldSec);
      page_q      <= '0;
      blink_q     <= 1'b0;
      blink_cnt_q <= '0;
      tmo_q       <= '0;
      display_q   <= 1'b0;
      setup_n_q   <= '1;
      blank_q     <= '0;
`ifdef AUTO_ROTATE_EN
      rot_q       <= '0;
`endif
    end else begin
      state_q     <= state_d;
      field_q     <= field_d;
      page_q      <= page_d;
      blink_q     <= blink_d;
      blink_cnt_q <= blink_cnt_d;
      tmo_q       <= tmo_d;
      display_q   <= (state_d == StSetup);
      setup_n_q   <= setup_n_d;
      blank_q     <= blank_d;
`ifdef AUTO_ROTATE_EN
      rot_q       <= rot_d;
`endif
    end
  end

  assign bus.display    = display_q;
  assign bus.setup_n    = setup_n_q;
  assign bus.field_idx  = field_q;
  assign bus.page_sel   = page_q;
  assign bus.blank_mask = blank_q;

endmodule
